// File: rtl/timer_bank_if.sv
// Control/status bundle for timer_bank: per-channel programming inputs and timer outputs.
interface timer_bank_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_CH     = 4,
    parameter int PRESCALE_W = 8
);
    logic [NUM_CH*WIDTH-1:0] threshold;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       stop;
    logic [NUM_CH-1:0]       irq_clr;
    logic [PRESCALE_W-1:0]   prescale;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       running;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH-1:0]       irq;
    logic                    tick;

    modport master (
        output threshold, mode, start, stop, irq_clr, prescale,
        input  count, running, done, irq, tick
    );

    modport slave (
        input  threshold, mode, start, stop, irq_clr, prescale,
        output count, running, done, irq, tick
    );
endinterface

// File: rtl/timer_bank.sv
// Multi-channel programmable interval timer with per-channel one-shot/periodic mode.
// Optional shared prescaler enabled by defining TIMER_BANK_PRESCALE_EN.
module timer_bank #(
    parameter int WIDTH      = 8,
    parameter int NUM_CH     = 4,
    parameter int PRESCALE_W = 8
) (
    input logic         clk,
    input logic         reset,
    timer_bank_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic                          tick_w;
    state_t                        state_q [NUM_CH];
    logic [NUM_CH-1:0][WIDTH-1:0]  cnt_q;
    logic [NUM_CH-1:0][WIDTH-1:0]  thr_q;
    logic [NUM_CH-1:0]             mode_q;
    logic [NUM_CH-1:0]             done_q;
    logic [NUM_CH-1:0]             irq_q;

`ifdef TIMER_BANK_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre_q;

    // A prescale drop below the current count wraps through 2^PRESCALE_W naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else if (pre_q == bus.prescale) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRESCALE_W'(1);
        end
    end

    assign tick_w = (pre_q == bus.prescale);
`else
    logic unused_prescale;

    assign unused_prescale = ^bus.prescale;
    assign tick_w          = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
            end
            cnt_q  <= '0;
            thr_q  <= '0;
            mode_q <= '0;
            done_q <= '0;
            irq_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                done_q[i] <= 1'b0;
                // Completion below overrides this clear in the same cycle.
                if (bus.irq_clr[i]) begin
                    irq_q[i] <= 1'b0;
                end
                if (bus.start[i]) begin
                    thr_q[i]   <= bus.threshold[i*WIDTH +: WIDTH];
                    mode_q[i]  <= bus.mode[i];
                    cnt_q[i]   <= '0;
                    state_q[i] <= RUN;
                end else if (bus.stop[i]) begin
                    state_q[i] <= IDLE;
                end else if (state_q[i] == RUN && tick_w) begin
                    // thr_q of 0 compares against all-ones, giving a 2^WIDTH period.
                    if (cnt_q[i] == thr_q[i] - ONE) begin
                        cnt_q[i]  <= '0;
                        done_q[i] <= 1'b1;
                        irq_q[i]  <= 1'b1;
                        if (!mode_q[i]) begin
                            state_q[i] <= IDLE;
                        end
                    end else begin
                        cnt_q[i] <= cnt_q[i] + ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.running = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.running[i] = (state_q[i] == RUN);
        end
    end

    assign bus.count = cnt_q;
    assign bus.done  = done_q;
    assign bus.irq   = irq_q;
    assign bus.tick  = tick_w;
endmodule
